// File: rtl/useq_timed_ctrl.sv
// useq_timed_ctrl: microcoded timing controller.
// One microword is fetched per cycle from a combinational ROM. The word sitting
// in the pipeline register drives the outputs and decides the next fetch
// address. The controller provides a prescaled delay timer, branches on
// synchronised external conditions, a CALL/RET return stack with sticky error
// detection, and HALT.
// Word layout: out[OUT_W] | op[3] | csel[3] | pol | const[CONST_W].
module useq_timed_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int OUT_W       = 4,
  parameter int CONST_W     = 8,
  parameter int PRE_SCALE   = 2,
  parameter int STACK_DEPTH = 4,
  parameter int COND_N      = 2,
  localparam int UW         = OUT_W + 7 + CONST_W
) (
  input  logic              clock_i,
  input  logic              reset_i,
  output logic [ADDR_W-1:0] uc_addr_o,
  input  logic [UW-1:0]     uc_data_i,
  input  logic [COND_N-1:0] cond_in_i,
  output logic [OUT_W-1:0]  out_o,
  output logic              halted_o,
  output logic              err_o
);

  localparam int CNT_W = CONST_W + PRE_SCALE;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_CONT  = 3'd0,
    OP_JMP   = 3'd1,
    OP_JCOND = 3'd2,
    OP_LDC   = 3'd3,
    OP_WAIT  = 3'd4,
    OP_CALL  = 3'd5,
    OP_RET   = 3'd6,
    OP_HALT  = 3'd7
  } op_e;

  logic [UW-1:0]      pipe_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SP_W-1:0]    sp_q;
  logic               err_q;
  logic [COND_N-1:0]  sync1_q, sync2_q;
  logic [ADDR_W-1:0]  stack_q [1 << PTR_W];

  // Microword field decode.
  op_e                op;
  logic [2:0]         csel;
  logic               pol;
  logic [CONST_W-1:0] konst;
  logic [ADDR_W-1:0]  target;
  logic [ADDR_W-1:0]  pc_inc;
  logic [SP_W-1:0]    sp_m1;

  assign op     = op_e'(pipe_q[CONST_W+6 -: 3]);
  assign csel   = pipe_q[CONST_W+3 -: 3];
  assign pol    = pipe_q[CONST_W];
  assign konst  = pipe_q[CONST_W-1:0];
  assign target = konst[ADDR_W-1:0];
  assign pc_inc = pc_q + ADDR_W'(1);
  assign sp_m1  = sp_q - SP_W'(1);

  // Condition vector: synchronised inputs, unused selects read 0, select 7 is timer expiry.
  logic [7:0] cond_vec;
  always_comb begin
    cond_vec              = '0;
    cond_vec[COND_N-1:0]  = sync2_q;
    cond_vec[7]           = (cnt_q == '0);
  end

  // Next-address selection and stack/timer/error control from the word in pipe.
  logic [ADDR_W-1:0] next_addr;
  logic              stop, push, pop, set_err, ldc;
  always_comb begin
    next_addr = pc_inc;
    stop      = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    set_err   = 1'b0;
    ldc       = 1'b0;
    if (err_q) begin
      stop = 1'b1;
    end else begin
      unique case (op)
        OP_CONT:  next_addr = pc_inc;
        OP_JMP:   next_addr = target;
        OP_JCOND: next_addr = (cond_vec[csel] ^ pol) ? target : pc_inc;
        OP_LDC:   ldc = 1'b1;
        OP_WAIT:  next_addr = (cnt_q != '0) ? pc_q : pc_inc;
        OP_CALL: begin
          if (sp_q == SP_W'(STACK_DEPTH)) begin
            stop    = 1'b1;
            set_err = 1'b1;
          end else begin
            push      = 1'b1;
            next_addr = target;
          end
        end
        OP_RET: begin
          if (sp_q == '0) begin
            stop    = 1'b1;
            set_err = 1'b1;
          end else begin
            pop       = 1'b1;
            next_addr = stack_q[sp_m1[PTR_W-1:0]];
          end
        end
        OP_HALT:  stop = 1'b1;
        default:  next_addr = pc_inc;
      endcase
    end
  end

  assign uc_addr_o = stop ? pc_q : next_addr;
  assign out_o     = pipe_q[UW-1 -: OUT_W];
  assign halted_o  = stop;
  assign err_o     = err_q;

  // Pipeline, program counter, timer, stack pointer, error flag and condition synchronisers.
  always_ff @(posedge clock_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset_i) begin
      pipe_q  <= '0;
      pc_q    <= '1;
      cnt_q   <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      pipe_q  <= uc_data_i;
      pc_q    <= uc_addr_o;
      sync1_q <= cond_in_i;
      sync2_q <= sync1_q;
      if (ldc) begin
        cnt_q <= CNT_W'(konst) << PRE_SCALE;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (push) begin
        sp_q <= sp_q + SP_W'(1);
      end else if (pop) begin
        sp_q <= sp_m1;
      end
      if (set_err) begin
        err_q <= 1'b1;
      end
    end
  end

  // Return-address stack storage.
  always_ff @(posedge clock_i) begin
    // NOTE: stack entries are not reset; only sp is, and no entry is read
    // before a CALL has written it.
    if (!reset_i && push) begin
      stack_q[sp_q[PTR_W-1:0]] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_useq_timed_ctrl.sv
// Self-checking bench for useq_timed_ctrl: directed programs in a behavioural
// ROM, expected per-cycle outputs queued in a scoreboard and popped as the
// cycles run.
module tb_useq_timed_ctrl;

  localparam int ADDR_W      = 4;
  localparam int OUT_W       = 4;
  localparam int CONST_W     = 8;
  localparam int PRE_SCALE   = 2;
  localparam int STACK_DEPTH = 4;
  localparam int COND_N      = 2;
  localparam int UW          = OUT_W + 7 + CONST_W;

  localparam int OP_CONT = 0, OP_JMP = 1, OP_JCOND = 2, OP_LDC = 3;
  localparam int OP_WAIT = 4, OP_CALL = 5, OP_RET = 6, OP_HALT = 7;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] uc_addr;
  logic [UW-1:0]     uc_data;
  logic [COND_N-1:0] cond_in;
  logic [OUT_W-1:0]  out;
  logic              halted;
  logic              err;

  logic [UW-1:0] rom [16];
  assign uc_data = rom[uc_addr];

  useq_timed_ctrl #(
    .ADDR_W(ADDR_W), .OUT_W(OUT_W), .CONST_W(CONST_W),
    .PRE_SCALE(PRE_SCALE), .STACK_DEPTH(STACK_DEPTH), .COND_N(COND_N)
  ) dut (
    .clock_i  (clk),
    .reset_i  (reset),
    .uc_addr_o(uc_addr),
    .uc_data_i(uc_data),
    .cond_in_i(cond_in),
    .out_o    (out),
    .halted_o (halted),
    .err_o    (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef enum int {S_OUT, S_ADDR, S_HALT, S_ERR} sig_e;
  typedef struct {
    int    cyc;
    sig_e  sig;
    int    val;
    string tag;
  } exp_t;
  exp_t sb[$];

  function automatic logic [UW-1:0] mkw(int o, int op, int cs, int pol, int k);
    return {OUT_W'(o), 3'(op), 3'(cs), 1'(pol), CONST_W'(k)};
  endfunction

  function automatic logic [31:0] observe(sig_e s);
    case (s)
      S_OUT:   return 32'(out);
      S_ADDR:  return 32'(uc_addr);
      S_HALT:  return 32'(halted);
      default: return 32'(err);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_at(input int cyc, input sig_e s, input int v, input string tag);
    exp_t e;
    e.cyc = cyc; e.sig = s; e.val = v; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance ncyc cycles, popping and comparing the expectations due at each one.
  task automatic run(input int ncyc);
    exp_t e;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        check(e.tag, observe(e.sig), 32'(e.val));
      end
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = mkw(15, OP_HALT, 0, 0, 0);
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check({name, "_rst_out"},    32'(out),     32'd0);
    check({name, "_rst_addr"},   32'(uc_addr), 32'd0);
    check({name, "_rst_halted"}, 32'(halted),  32'd0);
    check({name, "_rst_err"},    32'(err),     32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    cond_in = '0;
    clear_rom();

    // 1: simple loop 1,2,4 repeating.
    clear_rom();
    rom[0] = mkw(1, OP_CONT, 0, 0, 0);
    rom[1] = mkw(2, OP_CONT, 0, 0, 0);
    rom[2] = mkw(4, OP_JMP,  0, 0, 0);
    do_reset("t1");
    for (int i = 0; i < 6; i++) begin
      expect_at(i + 1, S_OUT,  (i % 3 == 0) ? 1 : (i % 3 == 1) ? 2 : 4, "t1_out");
      expect_at(i + 1, S_ADDR, (i % 3 == 2) ? 0 : (i % 3) + 1,          "t1_addr");
    end
    run(6);

    // 2: LDC 3 -> 12 ticks, WAIT holds for 13 cycles, then HALT.
    clear_rom();
    rom[0] = mkw(8, OP_LDC,  0, 0, 3);
    rom[1] = mkw(1, OP_WAIT, 0, 0, 0);
    rom[2] = mkw(2, OP_HALT, 0, 0, 0);
    do_reset("t2");
    expect_at(1, S_OUT, 8, "t2_ldc_out");
    for (int i = 2; i <= 14; i++) begin
      expect_at(i, S_OUT,  1, "t2_wait_out");
      expect_at(i, S_HALT, 0, "t2_wait_halted");
    end
    expect_at(14, S_ADDR, 2, "t2_wait_exit_addr");
    for (int i = 15; i <= 17; i++) begin
      expect_at(i, S_OUT,  2, "t2_halt_out");
      expect_at(i, S_HALT, 1, "t2_halt_halted");
      expect_at(i, S_ADDR, 2, "t2_halt_addr");
    end
    run(17);

    // 3: JCOND on synchronised cond_in[0]; no branch while low.
    clear_rom();
    rom[0] = mkw(1, OP_JCOND, 0, 0, 5);
    rom[1] = mkw(2, OP_JMP,   0, 0, 0);
    rom[5] = mkw(9, OP_HALT,  0, 0, 0);
    do_reset("t3");
    for (int i = 1; i <= 7; i++) begin
      expect_at(i, S_OUT,  (i % 2 == 1) ? 1 : 2, "t3_idle_out");
      expect_at(i, S_HALT, 0,                    "t3_idle_halted");
    end
    run(7);
    cond_in = 2'b01;
    expect_at(1, S_OUT, 2, "t3_sync_out1");
    expect_at(2, S_OUT, 1, "t3_sync_out2");
    expect_at(3, S_OUT, 9, "t3_branch_out");
    expect_at(3, S_HALT, 1, "t3_branch_halted");
    run(3);
    step();
    cond_in = 2'b00;
    expect_at(2, S_OUT, 9, "t3_hold_out");
    run(2);

    // 4: CALL 8 from address 1, RET returns to 2.
    clear_rom();
    rom[0] = mkw(1, OP_CONT, 0, 0, 0);
    rom[1] = mkw(2, OP_CALL, 0, 0, 8);
    rom[2] = mkw(3, OP_HALT, 0, 0, 0);
    rom[8] = mkw(4, OP_RET,  0, 0, 0);
    do_reset("t4");
    expect_at(1, S_ADDR, 1, "t4_addr_a");
    expect_at(2, S_OUT,  2, "t4_call_out");
    expect_at(2, S_ADDR, 8, "t4_call_addr");
    expect_at(3, S_OUT,  4, "t4_ret_out");
    expect_at(3, S_ADDR, 2, "t4_ret_addr");
    expect_at(4, S_OUT,  3, "t4_halt_out");
    expect_at(4, S_ERR,  0, "t4_err");
    run(4);

    // 5a: CALL chain one deeper than the stack.
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = mkw(i + 1, OP_CALL, 0, 0, i + 1);
    do_reset("t5");
    for (int i = 1; i <= 4; i++) begin
      expect_at(i, S_ADDR, i, "t5_call_addr");
      expect_at(i, S_HALT, 0, "t5_call_halted");
    end
    expect_at(5, S_OUT,  5, "t5_ovf_out");
    expect_at(5, S_HALT, 1, "t5_ovf_halted");
    expect_at(5, S_ADDR, 4, "t5_ovf_addr");
    expect_at(5, S_ERR,  0, "t5_ovf_err_pre");
    expect_at(6, S_ERR,  1, "t5_ovf_err");
    expect_at(6, S_HALT, 1, "t5_ovf_halted_hold");
    expect_at(6, S_OUT,  5, "t5_ovf_out_hold");
    run(6);

    // 5b: RET on an empty stack.
    clear_rom();
    rom[0] = mkw(6, OP_RET,  0, 0, 0);
    rom[1] = mkw(7, OP_HALT, 0, 0, 0);
    do_reset("t5b");
    expect_at(1, S_HALT, 1, "t5b_unf_halted");
    expect_at(1, S_ADDR, 0, "t5b_unf_addr");
    expect_at(2, S_ERR,  1, "t5b_unf_err");
    expect_at(2, S_OUT,  6, "t5b_unf_out");
    run(2);

    // 6: reset in the middle of a long WAIT, then clean restart.
    clear_rom();
    rom[0] = mkw(3, OP_WAIT, 0, 0, 0);
    rom[1] = mkw(5, OP_LDC,  0, 0, 20);
    rom[2] = mkw(6, OP_WAIT, 0, 0, 0);
    rom[3] = mkw(7, OP_JMP,  0, 0, 0);
    do_reset("t6");
    expect_at(1, S_OUT, 3, "t6_pre_out0");
    expect_at(2, S_OUT, 5, "t6_pre_out1");
    expect_at(33, S_OUT, 6, "t6_pre_wait");
    run(33);
    reset = 1'b1;
    expect_at(1, S_OUT,  0, "t6_rst_out");
    expect_at(1, S_ADDR, 0, "t6_rst_addr");
    expect_at(1, S_ERR,  0, "t6_rst_err");
    expect_at(1, S_HALT, 0, "t6_rst_halted");
    run(1);
    reset = 1'b0;
    expect_at(1, S_OUT,  3, "t6_re_wait0_out");
    expect_at(1, S_ADDR, 1, "t6_re_wait0_addr");
    expect_at(2, S_OUT,  5, "t6_re_ldc_out");
    for (int i = 3; i <= 83; i++) expect_at(i, S_OUT, 6, "t6_re_wait_out");
    expect_at(84, S_OUT,  7, "t6_re_jmp_out");
    expect_at(84, S_ADDR, 0, "t6_re_jmp_addr");
    expect_at(85, S_OUT,  3, "t6_re_loop_out");
    run(85);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
